// File: rtl/keypad_entry_ctrl_if.sv
// ----------------------------------------------------------------------------
// keypad_entry_ctrl_if
//   Bundles the keypad-side inputs and the digit-array-side outputs of
//   keypad_entry_ctrl. Clock and reset stay plain ports on the controller.
//
//   master : keypad encoder / test driver (drives key_valid, key_code, clear)
//   slave  : keypad_entry_ctrl (drives the slot array controls and status)
//
//   key_valid  encoder key-held level
//   key_code   encoder BCD digit
//   clear      synchronous entry clear (pulse or level)
//   slot_we    one-hot slot write enable
//   slot_data  digit to write, valid with any slot_we bit
//   slot_clr   one-cycle strobe clearing all slots
//   digit_cnt  digits captured so far
//   entry_full high while every slot holds a digit
//   entry_done one-cycle pulse on the write that fills the last slot
//   busy       a press or release is in progress
//   timeout    one-cycle pulse when a stale partial entry is discarded
// ----------------------------------------------------------------------------
interface keypad_entry_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  clear;
    logic [NUM_DIGITS-1:0] slot_we;
    logic [3:0]            slot_data;
    logic                  slot_clr;
    logic [3:0]            digit_cnt;
    logic                  entry_full;
    logic                  entry_done;
    logic                  busy;
    logic                  timeout;

    modport master (
        output key_valid, key_code, clear,
        input  slot_we, slot_data, slot_clr, digit_cnt,
               entry_full, entry_done, busy, timeout
    );

    modport slave (
        input  key_valid, key_code, clear,
        output slot_we, slot_data, slot_clr, digit_cnt,
               entry_full, entry_done, busy, timeout
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// ----------------------------------------------------------------------------
// keypad_entry_ctrl
//   Debounces keypad presses from the BCD encoder and writes one digit per
//   press into the next free slot of the digit register array, using one-hot
//   write enables in the single clk domain.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    keypad_entry_ctrl_if.slave (key inputs, slot controls, status)
//
//   Optional feature: define KEYPAD_TIMEOUT_EN to discard a partial entry
//   after TIMEOUT_CYCLES idle cycles (pulses timeout together with slot_clr).
//   Without it, timeout is tied low and a partial entry persists.
// ----------------------------------------------------------------------------
module keypad_entry_ctrl #(
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input logic                clk,
    input logic                rst_n,
    keypad_entry_ctrl_if.slave bus
);

    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [7:0]            DEB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [3:0]            CNT_FULL = 4'(NUM_DIGITS);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] WE_ONE   = NUM_DIGITS'(1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("keypad_entry_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_CAPTURE,
        S_RELEASE,
        S_FULL
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            code_q,  code_d;
    logic [7:0]            deb_q,   deb_d;
    logic [PTR_W-1:0]      ptr_q,   ptr_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic [NUM_DIGITS-1:0] we_q,    we_d;
    logic [3:0]            data_q,  data_d;
    logic                  clr_q,   clr_d;
    logic                  done_q,  done_d;
    logic                  tmo_q,   tmo_d;

    logic key_ok;
    logic same_key;
    logic tmo_hit;
    logic do_clr;

    // Codes 10..15 from the encoder are not digits and count as no key.
    assign key_ok   = bus.key_valid && (bus.key_code <= 4'd9);
    assign same_key = key_ok && (bus.key_code == code_q);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              partial;

    assign partial = (cnt_q != 4'd0) && (cnt_q != CNT_FULL);
    assign tmo_hit = (state_q == S_IDLE) && partial && (idle_q == IDLE_HIT);

    // Counts only while parked in IDLE on a partial entry; any exit from
    // IDLE (or any clear, including its own) restarts it.
    always_comb begin
        idle_d = '0;
        if (!do_clr && state_d == S_IDLE && partial)
            idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign do_clr = bus.clear || tmo_hit;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        deb_d   = deb_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = '0;
        data_d  = data_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        tmo_d   = tmo_hit;

        if (do_clr) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            deb_d   = '0;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (key_ok) begin
                        code_d  = bus.key_code;
                        deb_d   = 8'd1;
                        state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!same_key) begin
                        deb_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        deb_d = deb_q + 8'd1;
                        // The write strobe is armed here so it is on the
                        // slot array in the cycle right after the last
                        // stable sample, i.e. during CAPTURE.
                        if (deb_d == DEB_LAST) begin
                            state_d = S_CAPTURE;
                            we_d    = WE_ONE << ptr_q;
                            data_d  = code_q;
                            done_d  = (cnt_q + 4'd1 == CNT_FULL);
                        end
                    end
                end
                S_CAPTURE: begin
                    deb_d   = '0;
                    state_d = S_RELEASE;
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + 4'd1;
                        // Pointer parks on the last slot instead of wrapping.
                        if (ptr_q != PTR_LAST)
                            ptr_d = ptr_q + PTR_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (key_ok) begin
                        deb_d = '0;
                    end else begin
                        deb_d = deb_q + 8'd1;
                        if (deb_d == DEB_LAST) begin
                            deb_d   = '0;
                            state_d = (cnt_q == CNT_FULL) ? S_FULL : S_IDLE;
                        end
                    end
                end
                S_FULL: begin
                    state_d = S_FULL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            deb_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= '0;
            data_q  <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            deb_q   <= deb_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            data_q  <= data_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    // we_q/done_q are already on the wire during CAPTURE, so a clear that
    // lands in that cycle has to squash them here; the CAPTURE branch is
    // skipped by the clear, so count and pointer do not advance either.
    assign bus.slot_we    = we_q & {NUM_DIGITS{~bus.clear}};
    assign bus.entry_done = done_q & ~bus.clear;
    assign bus.slot_data  = data_q;
    assign bus.slot_clr   = clr_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.entry_full = (cnt_q == CNT_FULL);
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_FULL);
    assign bus.timeout    = tmo_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequencing controller between the keypad input encoder and the 6-slot 4-bit digit shift-register array. Takes the encoder's BCD code and key-valid level, debounces each press and writes one digit per press into the next free slot. Tracks the entry count, flags completion, and generates the clear strobe for the array. Replaces ad-hoc T-flip-flop clock gating with explicit one-hot slot write enables in a single clock domain.

Parameters:
NUM_DIGITS, 6, number of digit slots (1..8)
DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release (2..255)
TIMEOUT_CYCLES, 1000, idle cycles before partial entry is discarded (used only with the optional feature)

Ports:
clk  input  1  single system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
key_valid  input  1  encoder key-held level (encoder bit 4); synchronous to clk
key_code  input  4  encoder BCD digit (encoder bits 3:0)
clear  input  1  synchronous clear of the entry; single-cycle or level
slot_we  output  NUM_DIGITS  one-hot write enable; bit i writes slot i
slot_data  output  4  digit to write; valid when any slot_we bit is high
slot_clr  output  1  one-cycle strobe to clear all slots
digit_cnt  output  4  digits captured, 0..NUM_DIGITS
entry_full  output  1  level; high while digit_cnt == NUM_DIGITS
entry_done  output  1  one-cycle pulse on the write that fills the last slot
busy  output  1  high in any state other than IDLE and FULL
timeout  output  1  one-cycle pulse on inactivity discard (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; slot_we=0, slot_data=0, slot_clr=0, digit_cnt=0, entry_full=0, entry_done=0, busy=0, timeout=0; write pointer=0; debounce counter=0.
- Valid key: key_valid=1 and key_code <= 9. Codes 10..15 are treated as no key.
- IDLE: a valid key latches key_code, sets counter=1, and moves to DEBOUNCE.
- DEBOUNCE: key invalid or key_code differs from the latched code -> IDLE with no write. Otherwise counter++. When counter reaches DEBOUNCE_CYCLES -> CAPTURE.
- CAPTURE (exactly one cycle): slot_we[ptr]=1, slot_data=latched code, then ptr++ and digit_cnt++. If the new count == NUM_DIGITS, entry_done pulses in the same cycle. Next state is RELEASE.
- Latency: slot_we is high in the cycle immediately after the DEBOUNCE_CYCLES-th consecutive valid sample.
- RELEASE: needs DEBOUNCE_CYCLES consecutive samples with no valid key; any valid sample restarts the count. Then -> FULL if digit_cnt == NUM_DIGITS, else -> IDLE. A held key therefore writes only once.
- FULL: all keys ignored; entry_full=1; leaves only on clear or reset.
- slot_we and slot_data are registered outputs. slot_data holds its last value between writes.
- clear has the highest priority and acts in any state:
  - next state IDLE; ptr=0, digit_cnt=0, counter=0, entry_full=0.
  - slot_clr=1 for the following cycle.
  - If asserted during CAPTURE, the write is suppressed and entry_done does not pulse.
  - Held high, it keeps the block in IDLE, and slot_clr repeats every cycle.
- No wrap-around: ptr never exceeds NUM_DIGITS-1; writes are impossible in FULL.
- rst_n asserted mid-press: immediate return to reset values; the press is lost.

Optional Feature:
- KEYPAD_TIMEOUT_EN defined:
  - An idle counter runs in IDLE while 0 < digit_cnt < NUM_DIGITS.
  - It resets on leaving IDLE and on clear.
  - On reaching TIMEOUT_CYCLES, the block performs the clear action and pulses timeout for one cycle, coincident with slot_clr.
- KEYPAD_TIMEOUT_EN undefined: the timeout port is tied 0, no idle counter is built, and a partial entry persists indefinitely.

Test Plan:
- Reset then press 2 for 4 cycles (key_code=2) -> slot_we=000001, slot_data=2 in the next cycle; digit_cnt=1; single write even if held 20 cycles.
- Press 1 for 3 cycles then release -> no slot_we pulse, digit_cnt unchanged; code change 1->7 mid-debounce -> no write.
- Sequence 2,1,9,3,5,4 with 4-cycle press and 4-cycle release each:
  - slot_we walks 000001..100000 with data 2,1,9,3,5,4.
  - entry_done and entry_full assert on the 6th write.
  - A 7th press 8 causes no write.
- clear asserted in the CAPTURE cycle of the 3rd digit -> no write, slot_clr=1 next cycle, digit_cnt=0; the next press writes slot 0.
- key_code=12 with key_valid=1 for 10 cycles -> no write; rst_n pulled low mid-DEBOUNCE -> all outputs 0 asynchronously.
- KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=20: one digit entered then 20 idle cycles -> timeout and slot_clr pulse together, digit_cnt=0. Without the macro, timeout stays 0.
